window_shift_buffer: RTL
========================

# window_shift_buffer

Parameterised sliding-window row buffer for the sub-pixel interpolation datapath. It accepts one row of pixels per handshake and holds the last DEPTH rows. It presents them to the filter array as a flat window, in either row-major or transposed (column-major) order. Valid/ready handshakes on both sides let the upstream fetch stage and the downstream filter stall independently.

## Interface
Parameters:
- PIX_W, 8, bits per pixel
- ROW_PIX, 8, pixels per input row
- DEPTH, 15, rows held in the window (≥2)
- CNT_W, 16, width of window counter

Ports:
- clock  in  1  single clock, all state updates on posedge
- reset_L  in  1  synchronous, active-low reset
- flush  in  1  synchronous clear of contents and fill; samples cfg_transpose
- cfg_transpose  in  1  output ordering for the next fill, sampled on flush
- in_valid  in  1  in_row holds a valid row
- in_ready  out  1  buffer can accept a row this cycle
- in_row  in  ROW_PIX*PIX_W  pixel c at [c*PIX_W +: PIX_W]
- win_valid  out  1  window holds DEPTH valid rows
- win_ready  in  1  downstream consumes the current window
- win_out  out  DEPTH*ROW_PIX*PIX_W  window contents, layout per mode
- fill_count  out  $clog2(DEPTH+1)  rows currently held, saturating at DEPTH
- win_count  out  CNT_W  windows consumed since reset/flush, saturating
- transpose_q  out  1  currently latched mode

## Operation
- Storage: DEPTH row registers, row 0 = oldest.
- Row acceptance: a row is accepted when in_valid & in_ready.
  - Rows shift down one (row r ← row r+1).
  - Row DEPTH-1 ← in_row.
  - fill_count increments, saturating at DEPTH.
- in_ready = !flush & ((fill_count < DEPTH) | win_ready). When full, a new row is accepted only in the same cycle the current window is consumed.
- win_valid = (fill_count == DEPTH), driven from the register. A window is consumed on win_valid & win_ready, which increments win_count (saturating at 2^CNT_W−1).
- win_ready while !win_valid has no effect.
- Row-major (transpose_q=0): row r, pixel c at [(r*ROW_PIX + c)*PIX_W +: PIX_W].
- Transposed (transpose_q=1): column c occupies [c*DEPTH*PIX_W +: DEPTH*PIX_W]. Within it, row r, pixel c sits at offset r*PIX_W.
- win_out is combinational from the storage and transpose_q. It changes only on an accepted row, flush or reset.
- Flush:
  - Clears all rows to 0, fill_count to 0 and win_count to 0.
  - transpose_q ← cfg_transpose.
  - Any in_valid that cycle is dropped (in_ready is low).
  - A concurrent win_ready is not counted.
- Reset (reset_L=0): same as flush, except transpose_q ← 0. Reset has priority over flush.

## Timing
- Reset values: rows 0, fill_count 0, win_count 0, transpose_q 0, win_valid 0, win_out all-zero, in_ready 0 during reset and 1 the first cycle after.
- Latency: a row accepted at edge n appears in row DEPTH-1 of win_out after edge n. win_valid rises after the edge that accepts the DEPTH-th row.
- Steady state: one new window per cycle when in_valid and win_ready are both held high.
- Full with win_ready=0: in_ready=0, and contents and win_out are held indefinitely.
- Full with simultaneous consume and accept: the window shifts, fill_count stays at DEPTH, win_valid stays 1, and win_count increments.
- Consume without accept while full: win_count increments and contents are unchanged. The same window is re-presented as valid, so the downstream stage must not re-consume it unintentionally.
- Flush or reset mid-fill or mid-stream: takes effect at the next edge. win_valid is 0 the following cycle.
- fill_count never exceeds DEPTH. win_count never wraps.

## Structure
- Shared package `interp_pkg`: PIX_W and ROW_PIX defaults, a function computing the window width, and the transpose mode encoding (ROW_MAJOR=0, COL_MAJOR=1).
- One sub-module, `window_reorder`: a purely combinational row-major to column-major mapper parameterised on PIX_W, ROW_PIX and DEPTH. The top level muxes between its output and the raw storage on transpose_q.
- Top level holds the storage, fill and window counters, and handshake logic.

## Test plan
Defaults: PIX_W=8, ROW_PIX=8, DEPTH=15.
- Reset then 15 rows with row k = 8{k+1}, win_ready=0 → win_valid rises after the 15th accept. fill_count=15, in_ready=0. Row-major win_out row 0 = 0x0101…01 and row 14 = 0x0F0F…0F.
- Same fill after flush with cfg_transpose=1 → column 3 word = pixel bytes 01,02,…,0F at ascending offsets, and transpose_q=1.
- Full buffer, in_valid=1 and win_ready=1 for 10 cycles with rows 0x10…0x19 → 10 windows, win_count=10, row 14 = 8{0x19}, win_valid held at 1.
- Full buffer, win_ready=0 for 20 cycles with in_valid=1 → in_ready=0, win_out unchanged, win_count unchanged.
- Flush asserted at fill_count=7 with in_valid=1 → next cycle fill_count=0, win_out=0, the row is dropped, and win_valid stays 0.
- reset_L low mid-stream while transpose_q=1 → next cycle all counters 0, transpose_q=0, in_ready=1 after reset is released.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared definitions for the sub-pixel interpolation datapath: default pixel
// geometry, window width helper and the window ordering mode encoding.
package interp_pkg;

  localparam int PIX_W_DEF   = 8;
  localparam int ROW_PIX_DEF = 8;

  // Ordering of the flat window presented to the filter array.
  typedef enum logic {
    ROW_MAJOR = 1'b0,
    COL_MAJOR = 1'b1
  } transpose_mode_e;

  // Total number of bits in a window of depth rows.
  function automatic int win_width(input int pix_w, input int row_pix, input int depth);
    return pix_w * row_pix * depth;
  endfunction

endpackage

// File: rtl/window_reorder.sv
// Purely combinational row-major to column-major window mapper. Row r,
// pixel c of the input lands at offset r inside column word c of the output.
module window_reorder
  import interp_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int ROW_PIX = ROW_PIX_DEF,
  parameter int DEPTH   = 15
) (
  input  logic [PIX_W*ROW_PIX*DEPTH-1:0] row_major,
  output logic [PIX_W*ROW_PIX*DEPTH-1:0] col_major
);

  // Scatter every pixel from its row-major slot to its column-major slot.
  always_comb begin
    col_major = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < ROW_PIX; c++) begin
        col_major[(c*DEPTH + r)*PIX_W +: PIX_W] = row_major[(r*ROW_PIX + c)*PIX_W +: PIX_W];
      end
    end
  end

endmodule

// File: rtl/window_shift_buffer.sv
// Sliding-window row buffer. Holds the last DEPTH rows (row 0 oldest) and
// presents them as one flat window, row-major or transposed, with independent
// valid/ready handshakes towards the fetch stage and the filter array.
module window_shift_buffer
  import interp_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int ROW_PIX = ROW_PIX_DEF,
  parameter int DEPTH   = 15,
  parameter int CNT_W   = 16
) (
  input  logic                             clock,
  input  logic                             reset_L,
  input  logic                             flush,
  input  logic                             cfg_transpose,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ROW_PIX*PIX_W-1:0]         in_row,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic [DEPTH*ROW_PIX*PIX_W-1:0]   win_out,
  output logic [$clog2(DEPTH+1)-1:0]       fill_count,
  output logic [CNT_W-1:0]                 win_count,
  output logic                             transpose_q
);

  localparam int ROW_W  = PIX_W * ROW_PIX;
  localparam int WIN_W  = win_width(PIX_W, ROW_PIX, DEPTH);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FULL_COUNT = FILL_W'(DEPTH);

  // Row r lives at [r*ROW_W +: ROW_W], so the storage is already row-major.
  logic [WIN_W-1:0]  store_q;
  logic [FILL_W-1:0] fill_q;
  logic [CNT_W-1:0]  win_cnt_q;
  transpose_mode_e   mode_q;

  logic              full;
  logic              accept;
  logic              consume;
  logic [WIN_W-1:0]  col_major;

  // Handshake decode: a full buffer only takes a row when the window leaves.
  always_comb begin
    full      = (fill_q == FULL_COUNT);
    in_ready  = reset_L & ~flush & (~full | win_ready);
    accept    = in_valid & in_ready;
    consume   = reset_L & ~flush & full & win_ready;
  end

  // Row storage: shift towards row 0 and load the newest row at the top.
  always_ff @(posedge clock) begin
    if (!reset_L || flush) begin
      store_q <= '0;
    end else if (accept) begin
      store_q <= {in_row, store_q[WIN_W-1:ROW_W]};
    end
  end

  // Fill level: counts accepted rows and saturates once the window is full.
  always_ff @(posedge clock) begin
    if (!reset_L || flush) begin
      fill_q <= '0;
    end else if (accept && !full) begin
      fill_q <= fill_q + 1'b1;
    end
  end

  // Consumed-window counter, saturating so it never wraps.
  always_ff @(posedge clock) begin
    if (!reset_L || flush) begin
      win_cnt_q <= '0;
    end else if (consume && (win_cnt_q != '1)) begin
      win_cnt_q <= win_cnt_q + 1'b1;
    end
  end

  // Output ordering mode: forced to row-major by reset, reloaded on flush.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      mode_q <= ROW_MAJOR;
    end else if (flush) begin
      mode_q <= transpose_mode_e'(cfg_transpose);
    end
  end

  window_reorder #(
    .PIX_W   (PIX_W),
    .ROW_PIX (ROW_PIX),
    .DEPTH   (DEPTH)
  ) u_reorder (
    .row_major (store_q),
    .col_major (col_major)
  );

  // Present the window in the latched order along with the status counters.
  always_comb begin
    win_out     = (mode_q == COL_MAJOR) ? col_major : store_q;
    win_valid   = full;
    fill_count  = fill_q;
    win_count   = win_cnt_q;
    transpose_q = (mode_q == COL_MAJOR);
  end

endmodule
